poly_basemul: RTL
=================

# poly_basemul

Pointwise polynomial multiplier in the NTT domain. It consumes two 256-coefficient NTT-domain polynomials, as produced by the forward NTT block, and computes the Kyber base multiplication over 128 degree-1 pairs modulo X²−ζ. The product goes to the inverse NTT and accumulation stages. The block is a multi-cycle controller around 8 parallel pair multipliers.

## Interface
- Parameters:
- `LANES`, default 8: pair multipliers instantiated. Only 8 is supported; 16 coefficients per beat.
- Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: start request; sampled only in IDLE.
- `a_in`, input, 4096: polynomial a, signed 16-bit coefficients; coefficient i is at bits [16i +: 16].
- `b_in`, input, 4096: polynomial b, same packing as `a_in`.
- `out`, output, 4096: product polynomial r, same packing; held until the next run.
- `valid`, output, 1: high when `out` holds a completed result.

## Operation
- States are IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE with `enable`=1 at an edge:
  - copy `a_in` and `b_in` into internal buffers;
  - clear `valid`;
  - clear beat counter t;
  - go to ISSUE.
- IDLE with `enable`=0: hold. `enable` is ignored in every other state; a run cannot be aborted except by reset.
- ISSUE runs for t = 0..15. Each beat sends 8 pairs to lane L, with p = 8t+L:
  - operands a[2p], a[2p+1], b[2p], b[2p+1];
  - ζ = ZETAS[64 + p/2] when p is even, −ZETAS[64 + p/2] when p is odd.
  - After t = 15, go to DRAIN.
- Each lane computes:
  - r[2p] = fqmul(fqmul(a1,b1), ζ) + fqmul(a0,b0);
  - r[2p+1] = fqmul(a0,b1) + fqmul(a1,b0).
- fqmul is Montgomery multiplication: x·y·2⁻¹⁶ mod q, q = 3329, with result in (−q, q).
- Sums are 16-bit signed and do not overflow, since the range is (−2q, 2q).
- A lane-valid shift register tags each beat. Each result is written to the output buffer at its pair index when it leaves the lanes.
- DRAIN waits until the lane-valid pipe is empty, then goes to DONE.
- DONE: `out` ← output buffer, `valid` ← 1, go to IDLE.
- If `enable` is still high in IDLE after DONE, a new run starts at the next edge and `valid` drops at that edge.
- Reset (`reset`=0) overrides everything at the next edge:
  - state → IDLE;
  - all buffers, `out` and the beat counter → 0;
  - lane-valid pipe cleared, so no stale writes land after reset;
  - `valid` → 0.

## Timing
- Let E0 be the edge that samples `enable` in IDLE.
- Beats are issued at E1..E16. Lane latency is 2 cycles: products are registered, then the ζ product and the sums are registered.
- The output-buffer write happens at issue + 3. The last write is at E19.
- `out` and `valid` update at E20. Start-to-valid latency is 20 cycles.
- Back-to-back throughput is one run per 21 cycles, counting the IDLE sample edge.
- `out` and `valid` stay stable between runs.

## Configuration
- `POLY_BASEMUL_BARRETT_EN`
- Defined: each lane output passes through a registered Barrett reduction before the buffer write.
  - Coefficients become canonical in [0, q).
  - Lane latency is 3 and start-to-valid latency is 21.
- Undefined: raw sums in (−2q, 2q) and latency 20.
- Handshake and state sequence are identical in both builds.

## Structure
- Shared package `kyber_pkg` holds:
  - `KYBER_Q` = 3329;
  - `KYBER_N` = 256;
  - `MONT_R` = 2285 (2¹⁶ mod q);
  - the 128-entry signed 16-bit `ZETAS` table. Entry 64 is −1103 and entry 127 is 1628.
- The existing `fqmul` is reused unchanged.
- One sub-module, `basemul_unit`, contains one pair lane: 5 fqmul instances, the pipeline registers and the optional Barrett stage. The top module holds the FSM, buffers and lane-valid pipe.

## Test plan
- All-zero a and b, single `enable` pulse → `out` all 0; `valid` rises exactly 20 edges after the sampling edge (21 with the macro).
- Identity, unit b: a[2k] = 2285, a[2k+1] = 0, b[2k] = 5, b[2k+1] = 7 for all k → every r[2k] ≡ 5 and r[2k+1] ≡ 7 (mod 3329). With the macro, exactly 5 and 7.
- ζ routing: a[2p+1] = b[2p+1] = 2285, all other coefficients 0 →
  - r[0] ≡ −1103 and r[2] ≡ +1103;
  - r[252] ≡ 1628 and r[254] ≡ −1628 (mod q);
  - all odd-index outputs 0.
- Random a, b in (−q, q) across 50 runs → `out` matches the golden C basemul model mod q, plus an exact range check per build.
- Reset mid-run: drop `reset` at E8 for one cycle → `valid` = 0 and `out` = 0 next edge. No buffer write follows from the in-flight beats; a later run gives a correct result.
- `enable` held high continuously:
  - runs repeat every 21 cycles;
  - `valid` is high for exactly one cycle per run, then drops at each restart;
  - toggling `a_in` mid-run does not affect the result in progress.

Source files
------------

// File: rtl/kyber_pkg.sv
// ============================================================================
// Module      : kyber_pkg
// Description : Shared Kyber arithmetic constants, zeta table, basemul FSM
//               state encoding and the canonical Barrett reduction helper.
//               Lane latency depends on POLY_BASEMUL_BARRETT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kyber_pkg;

    localparam int KYBER_Q    = 3329;
    localparam int KYBER_N    = 256;
    localparam int MONT_R     = 2285;      // 2^16 mod q
    localparam int c_QINV     = -3327;     // q^-1 mod 2^16, signed
    localparam int c_BARRETT_V = 20159;    // round(2^26 / q)

`ifdef POLY_BASEMUL_BARRETT_EN
    localparam int c_LANE_LAT = 3;
`else
    localparam int c_LANE_LAT = 2;
`endif

    // Montgomery-domain twiddles in bit-reversed order
    localparam logic signed [15:0] ZETAS [0:127] = '{
        -16'sd1044,  -16'sd758,  -16'sd359, -16'sd1517,  16'sd1493,  16'sd1422,   16'sd287,   16'sd202,
         -16'sd171,   16'sd622,  16'sd1577,   16'sd182,   16'sd962, -16'sd1202, -16'sd1474,  16'sd1468,
          16'sd573, -16'sd1325,   16'sd264,   16'sd383,  -16'sd829,  16'sd1458, -16'sd1602,  -16'sd130,
         -16'sd681,  16'sd1017,   16'sd732,   16'sd608, -16'sd1542,   16'sd411,  -16'sd205, -16'sd1571,
         16'sd1223,   16'sd652,  -16'sd552,  16'sd1015, -16'sd1293,  16'sd1491,  -16'sd282, -16'sd1544,
          16'sd516,    -16'sd8,  -16'sd320,  -16'sd666, -16'sd1618, -16'sd1162,   16'sd126,  16'sd1469,
         -16'sd853,   -16'sd90,  -16'sd271,   16'sd830,   16'sd107, -16'sd1421,  -16'sd247,  -16'sd951,
         -16'sd398,   16'sd961, -16'sd1508,  -16'sd725,   16'sd448, -16'sd1065,   16'sd677, -16'sd1275,
        -16'sd1103,   16'sd430,   16'sd555,   16'sd843, -16'sd1251,   16'sd871,  16'sd1550,   16'sd105,
          16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,  16'sd1574,  16'sd1653,
         -16'sd246,   16'sd778,  16'sd1159,  -16'sd147,  -16'sd777,  16'sd1483,  -16'sd602,  16'sd1119,
        -16'sd1590,   16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,   -16'sd75,
          16'sd817,  16'sd1097,   16'sd603,   16'sd610,  16'sd1322, -16'sd1285, -16'sd1465,   16'sd384,
        -16'sd1215,  -16'sd136,  16'sd1218, -16'sd1335,  -16'sd874,   16'sd220, -16'sd1187, -16'sd1659,
        -16'sd1185, -16'sd1530, -16'sd1278,   16'sd794, -16'sd1510,  -16'sd854,  -16'sd870,   16'sd478,
         -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958, -16'sd1460,  16'sd1522,  16'sd1628
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } basemul_state_t;

    // Barrett reduction to the centred range, then folded into [0, q)
    function automatic logic signed [15:0] barrett_canon(input logic signed [15:0] x);
        logic signed [31:0] v_t;
        logic signed [15:0] v_r;
        v_t = (32'(x) * c_BARRETT_V + 32'sd33554432) >>> 26;
        v_r = x - 16'(v_t * KYBER_Q);
        if (v_r < 16'sd0) begin
            v_r = v_r + 16'(KYBER_Q);
        end
        return v_r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fqmul.sv
// ============================================================================
// Module      : fqmul
// Description : Combinational Montgomery multiply, a*b*2^-16 mod q, result
//               in (-q, q).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fqmul
    import kyber_pkg::*;
(
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic signed [15:0] o_r
);

    logic signed [31:0] w_prod;
    logic signed [15:0] w_t;
    logic signed [31:0] w_diff;

    // Full product followed by Montgomery reduction; low half of w_diff is zero
    always_comb begin
        w_prod = 32'(i_a) * 32'(i_b);
        w_t    = 16'(w_prod * c_QINV);
        w_diff = w_prod - 32'(w_t) * KYBER_Q;
        o_r    = 16'(w_diff >>> 16);
    end

endmodule

`default_nettype wire

// File: rtl/poly_basemul_unit.sv
// ============================================================================
// Module      : basemul_unit
// Description : One degree-1 pair multiplier modulo X^2 - zeta. Stage 1
//               registers the four cross products, stage 2 registers the
//               zeta product plus the sums. With POLY_BASEMUL_BARRETT_EN a
//               third stage canonicalises both outputs into [0, q).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module basemul_unit
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] i_a0,
    input  logic signed [15:0] i_a1,
    input  logic signed [15:0] i_b0,
    input  logic signed [15:0] i_b1,
    input  logic signed [15:0] i_zeta,
    output logic signed [15:0] o_r0,
    output logic signed [15:0] o_r1
);

    logic signed [15:0] w_a1b1;
    logic signed [15:0] w_a0b0;
    logic signed [15:0] w_a0b1;
    logic signed [15:0] w_a1b0;
    logic signed [15:0] w_a1b1z;

    logic signed [15:0] r_a1b1;
    logic signed [15:0] r_a0b0;
    logic signed [15:0] r_a0b1;
    logic signed [15:0] r_a1b0;
    logic signed [15:0] r_zeta;
    logic signed [15:0] r_sum0;
    logic signed [15:0] r_sum1;

    fqmul u_fq_a1b1 (.i_a(i_a1),   .i_b(i_b1),   .o_r(w_a1b1));
    fqmul u_fq_a0b0 (.i_a(i_a0),   .i_b(i_b0),   .o_r(w_a0b0));
    fqmul u_fq_a0b1 (.i_a(i_a0),   .i_b(i_b1),   .o_r(w_a0b1));
    fqmul u_fq_a1b0 (.i_a(i_a1),   .i_b(i_b0),   .o_r(w_a1b0));
    fqmul u_fq_zeta (.i_a(r_a1b1), .i_b(r_zeta), .o_r(w_a1b1z));

    // Stage 1: cross products, zeta travels alongside
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a1b1 <= '0;
            r_a0b0 <= '0;
            r_a0b1 <= '0;
            r_a1b0 <= '0;
            r_zeta <= '0;
        end else begin
            r_a1b1 <= w_a1b1;
            r_a0b0 <= w_a0b0;
            r_a0b1 <= w_a0b1;
            r_a1b0 <= w_a1b0;
            r_zeta <= i_zeta;
        end
    end

    // Stage 2: sums stay within (-2q, 2q) so 16 bits never overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sum0 <= '0;
            r_sum1 <= '0;
        end else begin
            r_sum0 <= w_a1b1z + r_a0b0;
            r_sum1 <= r_a0b1 + r_a1b0;
        end
    end

`ifdef POLY_BASEMUL_BARRETT_EN
    logic signed [15:0] r_red0;
    logic signed [15:0] r_red1;

    // Stage 3: canonical coefficients in [0, q)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_red0 <= '0;
            r_red1 <= '0;
        end else begin
            r_red0 <= barrett_canon(r_sum0);
            r_red1 <= barrett_canon(r_sum1);
        end
    end

    assign o_r0 = r_red0;
    assign o_r1 = r_red1;
`else
    assign o_r0 = r_sum0;
    assign o_r1 = r_sum1;
`endif

endmodule

`default_nettype wire

// File: rtl/poly_basemul.sv
// ============================================================================
// Module      : poly_basemul
// Description : NTT-domain pointwise multiplier. Latches both polynomials,
//               issues 16 beats of 8 pairs into the lane array, scatters the
//               tagged lane results into an output buffer and publishes it.
//               Build option POLY_BASEMUL_BARRETT_EN adds a canonicalising
//               lane stage (latency 21 instead of 20).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poly_basemul
    import kyber_pkg::*;
#(
    parameter int LANES = 8    // only 8 is supported: beat/lane index packing assumes it
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [16*KYBER_N-1:0]    a_in,
    input  logic [16*KYBER_N-1:0]    b_in,
    output logic [16*KYBER_N-1:0]    out,
    output logic                     valid
);

    basemul_state_t            r_state;
    logic [3:0]                r_beat;
    logic [16*KYBER_N-1:0]     r_abuf;
    logic [16*KYBER_N-1:0]     r_bbuf;
    logic [16*KYBER_N-1:0]     r_rbuf;
    logic [c_LANE_LAT:0]       r_vpipe;
    logic [c_LANE_LAT:0][3:0]  r_tag;
    logic                      w_issue;

    logic signed [15:0] w_r0 [LANES];
    logic signed [15:0] w_r1 [LANES];

    assign w_issue = (r_state == ST_ISSUE);

    // Control FSM, input capture and result publication
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_abuf  <= '0;
            r_bbuf  <= '0;
            out     <= '0;
            valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_abuf  <= a_in;
                        r_bbuf  <= b_in;
                        valid   <= 1'b0;
                        r_beat  <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_beat <= r_beat + 4'd1;
                    if (r_beat == 4'd15) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Only the top slot may still be occupied; it writes on this edge
                    if (r_vpipe[c_LANE_LAT-1:0] == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    out     <= r_rbuf;
                    valid   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Lane-valid and beat-tag pipe, aligned with the lane pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vpipe <= '0;
            r_tag   <= '0;
        end else begin
            r_vpipe <= {r_vpipe[c_LANE_LAT-1:0], w_issue};
            r_tag   <= {r_tag[c_LANE_LAT-1:0], r_beat};
        end
    end

    // Scatter lane results into the output buffer at their pair index
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rbuf <= '0;
        end else if (r_vpipe[c_LANE_LAT]) begin
            for (int l = 0; l < LANES; l++) begin
                r_rbuf[{r_tag[c_LANE_LAT], 3'(l), 5'd0}  +: 16] <= w_r0[l];
                r_rbuf[{r_tag[c_LANE_LAT], 3'(l), 5'd16} +: 16] <= w_r1[l];
            end
        end
    end

    for (genvar L = 0; L < LANES; L++) begin : g_lane
        logic [6:0]         w_p;
        logic [6:0]         w_zidx;
        logic signed [15:0] w_zeta;
        logic signed [15:0] r_a0;
        logic signed [15:0] r_a1;
        logic signed [15:0] r_b0;
        logic signed [15:0] r_b1;
        logic signed [15:0] r_zeta;

        // Pair p = 8t + L; zeta index 64 + p/2, negated for odd pairs
        assign w_p    = {r_beat, 3'(L)};
        assign w_zidx = {1'b1, r_beat, 2'(L / 2)};
        assign w_zeta = (L % 2 == 1) ? -ZETAS[w_zidx] : ZETAS[w_zidx];

        // Lane operand register, loaded on each issue beat
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_a0   <= '0;
                r_a1   <= '0;
                r_b0   <= '0;
                r_b1   <= '0;
                r_zeta <= '0;
            end else if (w_issue) begin
                r_a0   <= r_abuf[{w_p, 5'd0}  +: 16];
                r_a1   <= r_abuf[{w_p, 5'd16} +: 16];
                r_b0   <= r_bbuf[{w_p, 5'd0}  +: 16];
                r_b1   <= r_bbuf[{w_p, 5'd16} +: 16];
                r_zeta <= w_zeta;
            end
        end

        basemul_unit u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_a0   (r_a0),
            .i_a1   (r_a1),
            .i_b0   (r_b0),
            .i_b1   (r_b1),
            .i_zeta (r_zeta),
            .o_r0   (w_r0[L]),
            .o_r1   (w_r1[L])
        );
    end

endmodule

`default_nettype wire
